// File: rtl/sram_arbiter_ctrl.sv
// Two-port SRAM controller: the pixel read port has priority over the renderer write port.
// A starvation counter forces a write after a bounded run of read grants.
module sram_arbiter_ctrl #(
   parameter int ADDR_W        = 20,
   parameter int DATA_W        = 16,
   parameter int WR_STARVE_MAX = 4
) (
   input  logic              Clk,
   input  logic              Reset_N,
   input  logic              rd_req,
   input  logic [ADDR_W-1:0] rd_addr,
   output logic              rd_gnt,
   output logic              rd_valid,
   output logic [DATA_W-1:0] rd_data,
   input  logic              wr_req,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [DATA_W-1:0] wr_data,
   input  logic [1:0]        wr_be,
   output logic              wr_gnt,
   output logic              SRAM_CE,
   output logic              SRAM_OE,
   output logic              SRAM_WE,
   output logic              SRAM_UB,
   output logic              SRAM_LB,
   output logic [ADDR_W-1:0] SRAM_ADDR,
   inout  wire  [DATA_W-1:0] SRAM_DQ
);

   localparam int SW = $clog2(WR_STARVE_MAX + 1);
   localparam logic [SW-1:0] STARVE_MAX = SW'(WR_STARVE_MAX);

   typedef enum logic [1:0] {
      IDLE,
      RD,
      WR1,
      WR2
   } state_e;

   state_e            state_q, state_d;
   logic [SW-1:0]     starve_q, starve_d;
   logic              ce_q, ce_d;
   logic              oe_q, oe_d;
   logic              we_q, we_d;
   logic              ub_q, ub_d;
   logic              lb_q, lb_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [DATA_W-1:0] dout_q, dout_d;
   logic              doe_q, doe_d;
   logic              rd_valid_q, rd_valid_d;
   logic [DATA_W-1:0] rd_data_q, rd_data_d;
   logic              accept;

   // WR1 is the only cycle that cannot take a new request
   assign accept = Reset_N && (state_q != WR1);

   assign wr_gnt = accept && wr_req &&
                   (!rd_req || starve_q == STARVE_MAX);
   assign rd_gnt = accept && rd_req && !wr_gnt;

   always_comb begin
      state_d    = state_q;
      starve_d   = starve_q;
      ce_d       = ce_q;
      oe_d       = oe_q;
      we_d       = we_q;
      ub_d       = ub_q;
      lb_d       = lb_q;
      addr_d     = addr_q;
      dout_d     = dout_q;
      doe_d      = doe_q;
      rd_valid_d = 1'b0;
      rd_data_d  = rd_data_q;

      unique case (1'b1)
         wr_gnt: begin
            state_d = WR1;
            ce_d    = 1'b0;
            oe_d    = 1'b1;
            we_d    = 1'b0;
            ub_d    = ~wr_be[1];
            lb_d    = ~wr_be[0];
            addr_d  = wr_addr;
            dout_d  = wr_data;
            doe_d   = 1'b1;
         end
         rd_gnt: begin
            state_d = RD;
            ce_d    = 1'b0;
            oe_d    = 1'b0;
            we_d    = 1'b1;
            ub_d    = 1'b0;
            lb_d    = 1'b0;
            addr_d  = rd_addr;
            doe_d   = 1'b0;
         end
         (state_q == WR1): begin
            // address, data and byte lanes stay put for hold time
            state_d = WR2;
            we_d    = 1'b1;
         end
         default: begin
            state_d = IDLE;
            ce_d    = 1'b1;
            oe_d    = 1'b1;
            we_d    = 1'b1;
            ub_d    = 1'b1;
            lb_d    = 1'b1;
            doe_d   = 1'b0;
         end
      endcase

      if (!wr_req || wr_gnt) begin
         starve_d = '0;
      end else if (rd_gnt && starve_q != STARVE_MAX) begin
         starve_d = starve_q + 1'b1;
      end

      if (state_q == RD) begin
         rd_valid_d = 1'b1;
         rd_data_d  = SRAM_DQ;
      end
   end

   always_ff @(posedge Clk or negedge Reset_N) begin
      if (!Reset_N) begin
         state_q    <= IDLE;
         starve_q   <= '0;
         ce_q       <= 1'b1;
         oe_q       <= 1'b1;
         we_q       <= 1'b1;
         ub_q       <= 1'b1;
         lb_q       <= 1'b1;
         addr_q     <= '0;
         dout_q     <= '0;
         doe_q      <= 1'b0;
         rd_valid_q <= 1'b0;
         rd_data_q  <= '0;
      end else begin
         state_q    <= state_d;
         starve_q   <= starve_d;
         ce_q       <= ce_d;
         oe_q       <= oe_d;
         we_q       <= we_d;
         ub_q       <= ub_d;
         lb_q       <= lb_d;
         addr_q     <= addr_d;
         dout_q     <= dout_d;
         doe_q      <= doe_d;
         rd_valid_q <= rd_valid_d;
         rd_data_q  <= rd_data_d;
      end
   end

   assign SRAM_CE   = ce_q;
   assign SRAM_OE   = oe_q;
   assign SRAM_WE   = we_q;
   assign SRAM_UB   = ub_q;
   assign SRAM_LB   = lb_q;
   assign SRAM_ADDR = addr_q;
   assign SRAM_DQ   = doe_q ? dout_q : {DATA_W{1'bz}};
   assign rd_valid  = rd_valid_q;
   assign rd_data   = rd_data_q;

endmodule

// File: doc/sram_arbiter_ctrl.md
Name: sram_arbiter_ctrl

Overview:
- Synthesizable SRAM controller that owns the board SRAM pins (CE/UB/LB/OE/WE, 20-bit ADDR, 16-bit DQ).
- It is the responder for the frame-buffer traffic the SRAM unit-test top and the game top issue.
- Two request ports: a read port for the VGA pixel prefetcher and a write port for the sprite/frame renderer. Both share one async 10 ns SRAM on CLOCK_50.
- The read port has priority; a starvation guard guarantees the write port progress.

Parameters:
ADDR_W, 20, SRAM word-address width
DATA_W, 16, SRAM data width
WR_STARVE_MAX, 4, max consecutive read grants while wr_req is pending before a write is forced

Ports:
Clk  input  1  system clock (CLOCK_50 domain)
Reset_N  input  1  asynchronous, active-low reset
rd_req  input  1  read request (level; hold with rd_addr until rd_gnt)
rd_addr  input  ADDR_W  read word address
rd_gnt  output  1  combinational; read accepted at the end of this cycle
rd_valid  output  1  one-cycle pulse; rd_data valid
rd_data  output  DATA_W  read data (registered)
wr_req  input  1  write request (level; hold with wr_addr/wr_data/wr_be until wr_gnt)
wr_addr  input  ADDR_W  write word address
wr_data  input  DATA_W  write data
wr_be  input  2  byte enables: [1] upper, [0] lower; active high
wr_gnt  output  1  combinational; write accepted at the end of this cycle
SRAM_CE, SRAM_OE, SRAM_WE, SRAM_UB, SRAM_LB  output  1 each  active-low SRAM controls (registered)
SRAM_ADDR  output  ADDR_W  SRAM address (registered)
SRAM_DQ  inout  DATA_W  driven only during write states, else high-Z

Behaviour:
- Reset (async, Reset_N=0):
  - state=IDLE.
  - CE/OE/WE/UB/LB = 1; SRAM_ADDR = 0; DQ = Z.
  - rd_valid = 0; rd_data = 0; starve count = 0.
  - In-flight read is discarded: no rd_valid after reset release.
  - rd_gnt and wr_gnt are 0 while in reset.
- States: IDLE, RD, WR1, WR2.
- Accept slot: any cycle in IDLE, RD or WR2. At most one grant per cycle.
- Arbitration in an accept slot:
  - Grant the write if wr_req && (!rd_req || starve==WR_STARVE_MAX).
  - Else grant the read if rd_req.
  - A granted read with wr_req high increments starve, saturating at WR_STARVE_MAX.
  - A write grant or wr_req=0 clears starve.
- Read timing:
  - Grant in cycle C.
  - Cycle C+1 is RD: SRAM_ADDR=rd_addr, CE=0, OE=0, UB=LB=0, WE=1, DQ=Z.
  - At the end of C+1, rd_data<=SRAM_DQ and rd_valid<=1; rd_valid is high in C+2.
  - Back-to-back reads sustain 1 word/cycle with OE held low.
- Write timing:
  - Grant in cycle C.
  - WR1 (C+1): SRAM_ADDR=wr_addr, DQ=wr_data, CE=0, WE=0, OE=1, UB=~wr_be[1], LB=~wr_be[0].
  - WR2 (C+2): WE=1, ADDR/DQ/UB/LB held (hold time). WR2 is an accept slot.
  - Throughput: 1 write per 2 cycles.
- No request in an accept slot: next state IDLE, all controls deasserted (1), DQ=Z, SRAM_ADDR holds its last value.
- Grants are combinational from state, req and starve only. Each requester advances its request at the same edge it samples gnt=1; a held req is a new transaction.
- DQ turnaround: WR2→RD releases DQ at the same edge OE asserts. This is acceptable for the 10 ns part; no extra bubble.
- wr_be=2'b00 still performs a full WR1/WR2 cycle with UB=LB=1 (no-op on memory).
- No other buffering: latency is fixed and independent of traffic.

Test Plan:
- Reset with Reset_N=0 mid-RD → all SRAM controls=1, DQ=Z, rd_valid never pulses for that read. After release, state=IDLE and gnts=0 with no reqs.
- Single write addr=0x00010, data=0xBEEF, be=2'b11, then a read of 0x00010 → write pins as specified (WE low only in WR1). rd_gnt in cycle N, rd_valid in N+2 with rd_data=0xBEEF (SRAM model).
- Burst of 8 reads at addresses 0..7, rd_req held → rd_gnt every cycle, rd_valid every cycle starting 2 cycles after the first gnt, data matches the model in order.
- rd_req and wr_req held continuously → grant pattern R,R,R,R,W repeating. The write completes and starve resets after each W.
- Byte write be=2'b01 data=0x1234 to a word holding 0xAAAA → UB=1, LB=0 in WR1; read back returns 0xAA34.
- Simultaneous wr_req and rd_req with starve=0 → rd_gnt=1, wr_gnt=0. With rd_req dropped next cycle → wr_gnt=1 in the RD accept slot, WR1 the following cycle.
